// File: rtl/router_pkg.sv
// Shared types and default widths for the serial port router.
package router_pkg;

   localparam int BYTE_W = 8;
   localparam int LEN_W  = 6;
   localparam int PORT_W = 6;
   localparam int BLEN_W = $clog2(BYTE_W) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DONE
   } state_t;

   // Tag travelling with each emitted byte.
   typedef struct packed {
      logic [PORT_W-1:0] ports;
      logic [BLEN_W-1:0] len;
   } byte_tag_t;

endpackage

// File: rtl/blk_bit_counter.sv
// Block bit counter: counts sampled bits, latches the block length at start
// and flags when the bit being sampled this cycle reaches it (len 0 = 64).
module blk_bit_counter #(
   parameter int LEN_W = 6,
   parameter int POS_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             start,
   input  logic             inc,
   input  logic [LEN_W-1:0] len_in,
   output logic [POS_W-1:0] pos,
   output logic             hit,
   output logic             byte_full
);

   logic [LEN_W:0]   cnt_q;
   logic [LEN_W:0]   cnt_nxt;
   logic [LEN_W:0]   target;
   logic [LEN_W-1:0] len_q;

   // A zero length means a full wrap of the LEN_W-bit length field.
   function automatic logic [LEN_W:0] len_target(input logic [LEN_W-1:0] l);
      return (l == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, l};
   endfunction

   // Next count and active length target for this cycle's sample.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      cnt_nxt = cnt_q;
      target  = len_target(len_q);
      if (start) begin
         cnt_nxt = (LEN_W+1)'(1);
         target  = len_target(len_in);
      end else if (inc) begin
         cnt_nxt = cnt_q + (LEN_W+1)'(1);
      end
   end

   assign pos       = cnt_q[POS_W-1:0];
   assign hit       = (start | inc) && (cnt_nxt == target);
   assign byte_full = inc && (cnt_q[POS_W-1:0] == '1);

   // Count register and latched length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (start) begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         cnt_q <= cnt_nxt;
         len_q <= len_in;
      end else if (inc) begin
         cnt_q <= cnt_nxt;
      end
   end

endmodule

// File: rtl/serial_port_router.sv
// Serial port router: assembles LSB-first data bits into port-tagged bytes
// and reports block completion back to the packet controller.
module serial_port_router #(
   parameter int BYTE_W = router_pkg::BYTE_W,
   parameter int LEN_W  = router_pkg::LEN_W,
   parameter int PORT_W = router_pkg::PORT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      serin,
   input  logic                      valid,
   input  logic [PORT_W-1:0]         smbs_ports,
   input  logic [LEN_W-1:0]          num_of_inputs,
   output logic                      count_done,
   output logic [BYTE_W-1:0]         byte_out,
   output logic                      byte_valid,
   output logic [PORT_W-1:0]         byte_ports,
   output logic [$clog2(BYTE_W):0]   byte_len,
   output logic                      short_blk
);

   import router_pkg::*;

   localparam int POS_W = $clog2(BYTE_W);

   state_t            state;
   logic [BYTE_W-1:0] asm_q;
   logic [BYTE_W-1:0] asm_nxt;
   logic [PORT_W-1:0] ports_q;
   byte_tag_t         tag_q;
   logic [POS_W-1:0]  pos;
   logic [POS_W:0]    fill_len;
   logic              hit;
   logic              byte_full;
   logic              start;
   logic              inc;
   logic              clr;

   blk_bit_counter #(
      .LEN_W (LEN_W),
      .POS_W (POS_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .start     (start),
      .inc       (inc),
      .len_in    (num_of_inputs),
      .pos       (pos),
      .hit       (hit),
      .byte_full (byte_full)
   );

   // Counter controls and the assembly word with this cycle's bit inserted.
   always_comb begin
      start        = (state == IDLE) && valid;
      inc          = (state == RECV) && valid;
      clr          = (state != IDLE) && !valid;
      asm_nxt      = asm_q;
      asm_nxt[pos] = serin;
      fill_len     = {1'b0, pos} + (POS_W+1)'(1);
   end

   assign byte_ports = tag_q.ports;
   assign byte_len   = tag_q.len;

   // Block FSM with registered byte, tag and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         asm_q      <= '0;
         ports_q    <= '0;
         tag_q      <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         count_done <= 1'b0;
         short_blk  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         short_blk  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (valid) begin
                  ports_q <= smbs_ports;
                  if (hit) begin
                     // One-bit block completes on its first sample.
                     byte_out   <= asm_nxt;
                     tag_q      <= '{ports: smbs_ports, len: fill_len};
                     byte_valid <= 1'b1;
                     count_done <= 1'b1;
                     asm_q      <= '0;
                     state      <= DONE;
                  end else begin
                     asm_q <= asm_nxt;
                     state <= RECV;
                  end
               end
            end
            RECV: begin
               if (valid) begin
                  if (hit || byte_full) begin
                     byte_out   <= asm_nxt;
                     tag_q      <= '{ports: ports_q, len: fill_len};
                     byte_valid <= 1'b1;
                     asm_q      <= '0;
                  end else begin
                     asm_q <= asm_nxt;
                  end
                  if (hit) begin
                     count_done <= 1'b1;
                     state      <= DONE;
                  end
               end else begin
                  // Abort: flush whatever partial byte is held.
                  if (pos != '0) begin
                     byte_out   <= asm_q;
                     tag_q      <= '{ports: ports_q, len: {1'b0, pos}};
                     byte_valid <= 1'b1;
                  end
                  short_blk <= 1'b1;
                  asm_q     <= '0;
                  state     <= IDLE;
               end
            end
            DONE: begin
               if (!valid) begin
                  count_done <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_port_router.sv
// Scoreboard bench for serial_port_router: stimulus pushes expected bytes,
// a negedge monitor pops and compares whenever byte_valid is seen.
module tb_serial_port_router;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       serin = 1'b0;
   logic       valid = 1'b0;
   logic [5:0] smbs_ports = '0;
   logic [5:0] num_of_inputs = '0;
   logic       count_done;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic [5:0] byte_ports;
   logic [3:0] byte_len;
   logic       short_blk;

   typedef struct {
      logic [7:0] data;
      logic [5:0] ports;
      logic [3:0] len;
      logic       short_f;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   short_cnt = 0;

   serial_port_router dut (
      .clk           (clk),
      .rst           (rst),
      .serin         (serin),
      .valid         (valid),
      .smbs_ports    (smbs_ports),
      .num_of_inputs (num_of_inputs),
      .count_done    (count_done),
      .byte_out      (byte_out),
      .byte_valid    (byte_valid),
      .byte_ports    (byte_ports),
      .byte_len      (byte_len),
      .short_blk     (short_blk)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic [5:0] p, input logic [3:0] l, input logic s);
      exp_t e;
      e.data    = d;
      e.ports   = p;
      e.len     = l;
      e.short_f = s;
      exp_q.push_back(e);
   endtask

   // Drive n bits LSB-first; the first bit carries the block mask and length.
   task automatic run_block(input logic [5:0] mask, input logic [5:0] len,
                            input logic [63:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("count_done_low_in_block", count_done, 0);
         if (i == 0) begin
            smbs_ports    = mask;
            num_of_inputs = len;
         end
         valid = 1'b1;
         serin = bits[i];
      end
   endtask

   // Monitor: compare every strobe against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         if (short_blk) short_cnt++;
         if (byte_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", byte_out, 32'hDEAD);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("byte_out", byte_out, e.data);
               check("byte_ports", byte_ports, e.ports);
               check("byte_len", byte_len, e.len);
               check("short_with_byte", short_blk, e.short_f);
            end
         end else if (short_blk) begin
            check("unexpected_short_blk", short_blk, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, held and after release with valid low.
      repeat (2) @(negedge clk);
      check("rst_count_done", count_done, 0);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_byte_out", byte_out, 0);
      check("rst_short_blk", short_blk, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_count_done", count_done, 0);
      check("idle_byte_valid", byte_valid, 0);
      check("idle_byte_ports", byte_ports, 0);
      check("idle_byte_len", byte_len, 0);

      // Single full byte, count_done held while valid stays high.
      push(8'h4D, 6'b000101, 4'd8, 1'b0);
      run_block(6'b000101, 6'd8, 64'h4D, 8);
      @(negedge clk);
      check("single_cd_set", count_done, 1);
      valid = 1'b1;
      serin = 1'b1;
      @(negedge clk);
      check("single_cd_held", count_done, 1);
      valid = 1'b0;
      @(negedge clk);
      check("single_cd_clear", count_done, 0);

      // Full byte followed by a 3-bit partial byte.
      push(8'hFF, 6'h0A, 4'd8, 1'b0);
      push(8'h07, 6'h0A, 4'd3, 1'b0);
      run_block(6'h0A, 6'd11, 64'h7FF, 11);
      @(negedge clk);
      check("partial_cd_set", count_done, 1);
      valid = 1'b0;
      @(negedge clk);
      check("partial_cd_clear", count_done, 0);

      // Abort after 5 of 10 bits.
      push(8'h13, 6'h30, 4'd5, 1'b1);
      run_block(6'h30, 6'd10, 64'h13, 5);
      @(negedge clk);
      valid = 1'b0;
      check("abort_cd_pre", count_done, 0);
      @(negedge clk);
      check("abort_cd_post", count_done, 0);

      // Two len-3 blocks, extra bit in DONE, one-cycle endcheck gap.
      push(8'h05, 6'h11, 4'd3, 1'b0);
      run_block(6'h11, 6'd3, 64'h5, 3);
      @(negedge clk);
      check("rep1_cd_set", count_done, 1);
      valid = 1'b1;
      serin = 1'b1;
      @(negedge clk);
      check("rep1_cd_held", count_done, 1);
      valid = 1'b0;
      push(8'h06, 6'h22, 4'd3, 1'b0);
      run_block(6'h22, 6'd3, 64'h6, 3);
      @(negedge clk);
      check("rep2_cd_set", count_done, 1);
      valid = 1'b0;
      @(negedge clk);
      check("rep2_cd_clear", count_done, 0);

      // len 0 means 64 bits: eight bytes, LSB byte first.
      push(8'hEF, 6'h2A, 4'd8, 1'b0);
      push(8'hCD, 6'h2A, 4'd8, 1'b0);
      push(8'hAB, 6'h2A, 4'd8, 1'b0);
      push(8'h89, 6'h2A, 4'd8, 1'b0);
      push(8'h67, 6'h2A, 4'd8, 1'b0);
      push(8'h45, 6'h2A, 4'd8, 1'b0);
      push(8'h23, 6'h2A, 4'd8, 1'b0);
      push(8'h01, 6'h2A, 4'd8, 1'b0);
      run_block(6'h2A, 6'd0, 64'h0123_4567_89AB_CDEF, 64);
      @(negedge clk);
      check("len0_cd_set", count_done, 1);
      valid = 1'b0;
      @(negedge clk);
      check("len0_cd_clear", count_done, 0);

      // Reset after 4 bits: nothing may be emitted.
      run_block(6'h07, 6'd20, 64'hF, 4);
      @(negedge clk);
      rst   = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      check("midrst_byte_valid", byte_valid, 0);
      check("midrst_short_blk", short_blk, 0);
      rst = 1'b1;
      @(negedge clk);
      check("postrst_byte_valid", byte_valid, 0);
      check("postrst_short_blk", short_blk, 0);

      // Fresh block with all ports selected.
      push(8'h09, 6'h3F, 4'd4, 1'b0);
      run_block(6'h3F, 6'd4, 64'h9, 4);
      @(negedge clk);
      check("mask3f_cd_set", count_done, 1);
      valid = 1'b0;
      @(negedge clk);
      check("mask3f_cd_clear", count_done, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      check("short_blk_pulses", short_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
